// File: rtl/nns_scan_ctrl.sv
// rtl/nns_scan_ctrl.sv - exhaustive 1-nearest-neighbour (taxicab) scan over an N-entry point RAM
module nns_scan_ctrl #(
   parameter int W  = 15,
   parameter int N  = 16,
   parameter int AW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2*W-1:0]  query,
   output logic            mem_rd,
   output logic [AW-1:0]   mem_addr,
   input  logic [2*W-1:0]  mem_data,
   output logic            busy,
   output logic            done,
   output logic [AW-1:0]   best_idx,
   output logic [2*W-1:0]  best_val,
   output logic [W+1:0]    best_dist
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   localparam logic [AW-1:0] LAST = AW'(N - 1);

   state_t           state, state_n;
   logic [AW-1:0]    cnt;
   logic [AW-1:0]    a_d;
   logic             v;
   logic [2*W-1:0]   q;
   logic [W-1:0]     xq, yq, xm, ym, dx, dy;
   logic [W+1:0]     d;
   logic             accept;

   assign accept = (state == IDLE) && start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (cnt == LAST) state_n = FLUSH;
         FLUSH:   state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Outputs decode straight from state so an async reset drops them at once.
   assign mem_rd   = (state == RUN);
   assign mem_addr = cnt;
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   assign xq = q[2*W-1:W];
   assign yq = q[W-1:0];
   assign xm = mem_data[2*W-1:W];
   assign ym = mem_data[W-1:0];
   assign dx = (xq >= xm) ? (xq - xm) : (xm - xq);
   assign dy = (yq >= ym) ? (yq - ym) : (ym - yq);
   assign d  = {2'b00, dx} + {2'b00, dy};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         a_d       <= '0;
         v         <= 1'b0;
         q         <= '0;
         best_idx  <= '0;
         best_val  <= '0;
         best_dist <= '1;
      end else begin
         v   <= (state == RUN);
         a_d <= cnt;
         if (accept) begin
            q         <= query;
            cnt       <= '0;
            best_idx  <= '0;
            best_val  <= '0;
            best_dist <= '1;
         end else begin
            if (state == RUN) cnt <= cnt + AW'(1);
            // Strict compare: on ties the earlier (lower) address wins.
            if (v && (d < best_dist)) begin
               best_dist <= d;
               best_val  <= mem_data;
               best_idx  <= a_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_nns_scan_ctrl.sv
// tb/tb_nns_scan_ctrl.sv - directed self-checking bench for nns_scan_ctrl
module tb_nns_scan_ctrl;

   localparam int W  = 15;
   localparam int N  = 16;
   localparam int AW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [2*W-1:0]  query;
   logic            mem_rd;
   logic [AW-1:0]   mem_addr;
   logic [2*W-1:0]  mem_data;
   logic            busy;
   logic            done;
   logic [AW-1:0]   best_idx;
   logic [2*W-1:0]  best_val;
   logic [W+1:0]    best_dist;

   logic [2*W-1:0]  ram [N];

   int errors = 0;
   int checks = 0;

   nns_scan_ctrl #(.W(W), .N(N), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .query     (query),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .busy      (busy),
      .done      (done),
      .best_idx  (best_idx),
      .best_val  (best_val),
      .best_dist (best_dist)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (mem_rd) mem_data <= ram[mem_addr];
   end

   function automatic logic [2*W-1:0] pt(input int x, input int y);
      logic [W-1:0] xx, yy;
      xx = x[W-1:0];
      yy = y[W-1:0];
      return {xx, yy};
   endfunction

   task automatic load_ramp();
      for (int i = 0; i < N; i++) ram[i] = pt(10 * i, 10 * i);
   endtask

   // Accept a search at edge c0, then follow it cycle by cycle until done.
   // lat = cycles from c0 to done; seq_ok = mem_rd/mem_addr/busy matched the timeline.
   task automatic run_search(input logic [2*W-1:0] q, output int lat, output bit seq_ok);
      lat    = -1;
      seq_ok = 1'b1;
      @(negedge clk);
      start = 1'b1;
      query = q;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k <= N) begin
            if (!(mem_rd === 1'b1 && mem_addr === AW'(k - 1))) seq_ok = 1'b0;
         end else if (mem_rd !== 1'b0) seq_ok = 1'b0;
         if (busy !== 1'b1) seq_ok = 1'b0;
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      query = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({mem_rd, mem_addr, busy, done, best_idx, best_val} !== '0 || best_dist !== '1) begin
         errors++;
         $display("FAIL reset_state: rd=%0b addr=%0d busy=%0b done=%0b idx=%0d val=%h dist=%h, need all zero and dist=1ffff",
                  mem_rd, mem_addr, busy, done, best_idx, best_val, best_dist);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_ramp();
      int lat;
      bit ok;
      load_ramp();
      run_search(pt(100, 100), lat, ok);
      checks++;
      if (lat !== N + 2) begin
         errors++; $display("FAIL ramp_latency: got %0d need %0d", lat, N + 2);
      end
      checks++;
      if (!ok) begin
         errors++; $display("FAIL ramp_sequence: got %0b need 1", ok);
      end
      checks++;
      if (best_idx !== 4'd10 || best_val !== pt(100, 100) || best_dist !== 17'd0) begin
         errors++;
         $display("FAIL ramp_result: got idx=%0d val=%h dist=%0d need idx=10 val=%h dist=0",
                  best_idx, best_val, best_dist, pt(100, 100));
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || best_idx !== 4'd10 || best_dist !== 17'd0) begin
         errors++;
         $display("FAIL ramp_hold: got busy=%0b done=%0b idx=%0d dist=%0d need 0 0 10 0",
                  busy, done, best_idx, best_dist);
      end
   endtask

   task automatic test_tie();
      int lat;
      bit ok;
      for (int i = 0; i < N; i++) ram[i] = pt(1000, 1000);
      ram[3] = pt(40, 50);
      ram[7] = pt(60, 50);
      run_search(pt(50, 50), lat, ok);
      checks++;
      if (lat !== N + 2 || best_idx !== 4'd3 || best_val !== pt(40, 50) || best_dist !== 17'd10) begin
         errors++;
         $display("FAIL tie: got lat=%0d idx=%0d val=%h dist=%0d need lat=18 idx=3 val=%h dist=10",
                  lat, best_idx, best_val, best_dist, pt(40, 50));
      end
   endtask

   task automatic test_extremes();
      int lat;
      bit ok;
      for (int i = 0; i < N; i++) ram[i] = pt(32767, 32767);
      ram[15] = pt(32767, 32766);
      run_search(pt(0, 0), lat, ok);
      checks++;
      if (lat !== N + 2 || best_idx !== 4'd15 || best_val !== pt(32767, 32766) || best_dist !== 17'd65533) begin
         errors++;
         $display("FAIL extremes: got lat=%0d idx=%0d val=%h dist=%0d need lat=18 idx=15 val=%h dist=65533",
                  lat, best_idx, best_val, best_dist, pt(32767, 32766));
      end
      ram[15] = pt(32767, 32767);
      run_search(pt(0, 0), lat, ok);
      checks++;
      if (best_idx !== 4'd0 || best_dist !== 17'd65534) begin
         errors++;
         $display("FAIL extremes_max: got idx=%0d dist=%0d need idx=0 dist=65534", best_idx, best_dist);
      end
   endtask

   task automatic test_protocol();
      bit ok;
      int busy_cnt;
      int done_at;
      load_ramp();
      ok       = 1'b1;
      busy_cnt = 0;
      done_at  = -1;
      @(negedge clk);
      start = 1'b1;
      query = pt(100, 100);
      @(posedge clk);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 4) query = pt(0, 0);
         if (k <= 19 && busy === 1'b1) busy_cnt++;
         if (k <= N && !(mem_rd === 1'b1 && mem_addr === AW'(k - 1))) ok = 1'b0;
         if (k > N && k <= 19 && mem_rd !== 1'b0) ok = 1'b0;
         if (done === 1'b1 && done_at < 0) done_at = k;
         if (k == 19 && busy !== 1'b0) ok = 1'b0;
         if (k == 20 && !(busy === 1'b1 && mem_rd === 1'b1 && mem_addr === 4'd0)) ok = 1'b0;
         if (k == N + 2) begin
            checks++;
            if (best_idx !== 4'd10 || best_dist !== 17'd0) begin
               errors++;
               $display("FAIL protocol_result: got idx=%0d dist=%0d need idx=10 dist=0", best_idx, best_dist);
            end
         end
      end
      start = 1'b0;
      checks++;
      if (busy_cnt !== N + 2 || done_at !== N + 2) begin
         errors++;
         $display("FAIL protocol_window: got busy=%0d done_at=%0d need %0d %0d", busy_cnt, done_at, N + 2, N + 2);
      end
      checks++;
      if (!ok) begin
         errors++; $display("FAIL protocol_sequence: got %0b need 1", ok);
      end
      for (int k = 0; k < 40 && busy === 1'b1; k++) @(negedge clk);
      checks++;
      if (best_idx !== 4'd0 || best_dist !== 17'd0) begin
         errors++;
         $display("FAIL protocol_second: got idx=%0d dist=%0d need idx=0 dist=0", best_idx, best_dist);
      end
   endtask

   task automatic test_mid_reset();
      int lat;
      bit ok;
      bit seen_done;
      load_ramp();
      @(negedge clk);
      start = 1'b1;
      query = pt(100, 100);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || mem_rd !== 1'b0 || done !== 1'b0 || best_dist !== '1 || best_idx !== '0) begin
         errors++;
         $display("FAIL mid_reset: got busy=%0b rd=%0b done=%0b dist=%h idx=%0d need 0 0 0 1ffff 0",
                  busy, mem_rd, done, best_dist, best_idx);
      end
      @(negedge clk);
      rst = 1'b0;
      seen_done = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
      end
      checks++;
      if (seen_done) begin
         errors++; $display("FAIL mid_reset_quiet: got activity=1 need 0");
      end
      run_search(pt(100, 100), lat, ok);
      checks++;
      if (lat !== N + 2 || !ok || best_idx !== 4'd10 || best_dist !== 17'd0) begin
         errors++;
         $display("FAIL mid_reset_rerun: got lat=%0d seq=%0b idx=%0d dist=%0d need 18 1 10 0",
                  lat, ok, best_idx, best_dist);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      bit ok;
      load_ramp();
      run_search(pt(35, 45), lat, ok);
      checks++;
      if (best_idx !== 4'd4 || best_val !== pt(40, 40) || best_dist !== 17'd10) begin
         errors++;
         $display("FAIL b2b_first: got idx=%0d val=%h dist=%0d need idx=4 val=%h dist=10",
                  best_idx, best_val, best_dist, pt(40, 40));
      end
      @(negedge clk);
      start = 1'b1;
      query = pt(160, 150);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      checks++;
      if (best_dist !== '1 || best_idx !== '0 || best_val !== '0) begin
         errors++;
         $display("FAIL b2b_reinit: got idx=%0d val=%h dist=%h need 0 0 1ffff", best_idx, best_val, best_dist);
      end
      for (int k = 0; k < 40 && done !== 1'b1; k++) @(negedge clk);
      checks++;
      if (done !== 1'b1 || best_idx !== 4'd15 || best_val !== pt(150, 150) || best_dist !== 17'd10) begin
         errors++;
         $display("FAIL b2b_second: got done=%0b idx=%0d val=%h dist=%0d need 1 15 %h 10",
                  done, best_idx, best_val, best_dist, pt(150, 150));
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_tie();
      test_extremes();
      test_protocol();
      test_mid_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
